inst_mem: RTL and testbench

Instruction memory responder for the IF stage: it answers the fetch requests (`ce`, byte `pc`) that the program counter register issues each cycle. It returns one instruction word per request with one-cycle registered latency, and holds its output while IF/ID is stalled. A sequential load port fills the array before execution: a word counter under a valid/ready handshake, gated by a three-state controller.

---
 rtl/inst_mem_if.sv | 25 ++
 rtl/inst_mem.sv | 70 +++++++
 tb/tb_inst_mem.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_if.sv
// inst_mem_if: fetch, stall and program-load signals between the pipeline/loader and inst_mem
interface inst_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ce_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [5:0]            stall_i;
  logic                  load_start_i;
  logic                  load_valid_i;
  logic [31:0]           load_data_i;
  logic                  load_last_i;
  logic                  load_ready_o;
  logic                  load_done_o;
  logic [31:0]           inst_o;
  logic                  inst_valid_o;
  logic                  fault_o;
  modport master (
    output ce_i, addr_i, stall_i, load_start_i, load_valid_i, load_data_i, load_last_i,
    input  load_ready_o, load_done_o, inst_o, inst_valid_o, fault_o
  );
  modport slave (
    input  ce_i, addr_i, stall_i, load_start_i, load_valid_i, load_data_i, load_last_i,
    output load_ready_o, load_done_o, inst_o, inst_valid_o, fault_o
  );
endinterface

// File: rtl/inst_mem.sv
// inst_mem: registered instruction memory with stall hold, fetch fault flagging and a sequential load port
module inst_mem #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  inst_mem_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t                state, state_n;
  logic [IW-1:0]         cnt;
  logic [31:0]           mem [DEPTH];
  logic                  ready_q, done_q, valid_q, fault_q;
  logic [31:0]           inst_q;
  logic                  accept, last_beat, misalign, oor, bad;
  logic [ADDR_WIDTH-1:0] hi;
  logic                  unused_stall;
  assign accept       = bus.load_valid_i && ready_q;
  assign last_beat    = accept && (bus.load_last_i || cnt == IW'(DEPTH - 1));
  // any bit above the word index means out of range; nothing is truncated into the array
  assign hi           = bus.addr_i >> (IW + 2);
  assign misalign     = |bus.addr_i[1:0];
  assign oor          = |hi;
  assign bad          = misalign || oor;
  assign unused_stall = ^{bus.stall_i[5:2], bus.stall_i[0]};
  always_comb begin
    state_n = (state == LOAD) ? (last_beat ? RUN : LOAD)
                              : (bus.load_start_i ? LOAD : state);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= state_n == LOAD;
      done_q  <= state == LOAD && state_n == RUN;
      cnt     <= (state != LOAD && state_n == LOAD) ? '0 : accept ? cnt + IW'(1) : cnt;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) mem[cnt] <= bus.load_data_i;
  end
  // leaving RUN beats the stall hold; otherwise a stalled IF/ID keeps its word
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (state != RUN || bus.load_start_i) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!bus.stall_i[1]) begin
      inst_q  <= (!bus.ce_i || bad) ? NOP : mem[bus.addr_i[IW+1:2]];
      valid_q <= bus.ce_i && !bad;
      fault_q <= bus.ce_i && bad;
    end
  end
  assign bus.load_ready_o = ready_q;
  assign bus.load_done_o  = done_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = valid_q;
  assign bus.fault_o      = fault_q;
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed stimulus with a cycle-tagged scoreboard checked by a negedge monitor
module tb_inst_mem;
  localparam int          AW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  typedef struct packed {
    int          cyc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
    logic        ready;
    logic        done;
  } exp_t;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  exp_t        sb[$];
  string       nm[$];
  exp_t        e;
  string       n;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] w4 [4];
  always #5 clk_i = ~clk_i;
  inst_mem_if #(.ADDR_WIDTH(AW)) bus();
  inst_mem #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .bus(bus)
  );
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n = nm.pop_front();
      tests++;
      if (e.cyc != cyc || bus.inst_o !== e.inst || bus.inst_valid_o !== e.valid ||
          bus.fault_o !== e.fault || bus.load_ready_o !== e.ready || bus.load_done_o !== e.done) begin
        fails++;
        $display("FAIL %s cyc=%0d/%0d: got inst=%h v=%b f=%b rdy=%b done=%b, want inst=%h v=%b f=%b rdy=%b done=%b",
                 n, cyc, e.cyc, bus.inst_o, bus.inst_valid_o, bus.fault_o, bus.load_ready_o,
                 bus.load_done_o, e.inst, e.valid, e.fault, e.ready, e.done);
      end
    end
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic exp_at(input int c, input string s, input logic [31:0] i,
                        input logic v, input logic f, input logic r, input logic d);
    sb.push_back('{c, i, v, f, r, d});
    nm.push_back(s);
  endtask
  task automatic fetch(input logic ce, input logic [31:0] a, input logic [5:0] st);
    bus.ce_i    = ce;
    bus.addr_i  = a;
    bus.stall_i = st;
  endtask
  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    bus.load_valid_i = v;
    bus.load_data_i  = d;
    bus.load_last_i  = l;
  endtask
  initial begin
    w4 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    fetch(0, 0, 0);
    beat(0, 0, 0);
    bus.load_start_i = 0;
    exp_at(1, "reset", NOP, 0, 0, 0, 0);
    tick();
    rst_n_i = 1;
    fetch(1, 0, 0);
    exp_at(cyc + 1, "idle_fetch", NOP, 0, 0, 0, 0);
    tick();
    fetch(0, 0, 0);
    bus.load_start_i = 1;
    exp_at(cyc + 1, "load_start", NOP, 0, 0, 1, 0);
    tick();
    bus.load_start_i = 0;
    for (int i = 0; i < 4; i++) begin
      beat(1, w4[i], i == 3);
      if (i == 3) exp_at(cyc + 1, "load_done", NOP, 0, 0, 0, 1);
      else        exp_at(cyc + 1, "load_beat", NOP, 0, 0, 1, 0);
      tick();
    end
    beat(0, 0, 0);
    exp_at(cyc + 1, "done_clears", NOP, 0, 0, 0, 0);
    tick();
    fetch(1, 0, 0);
    exp_at(cyc + 1, "fetch0", w4[0], 1, 0, 0, 0);
    tick();
    for (int k = 1; k < 4; k++) begin
      fetch(1, 32'(4 * k), 6'b000010);
      exp_at(cyc + 1, "stall_hold", w4[0], 1, 0, 0, 0);
      tick();
    end
    for (int k = 1; k < 4; k++) begin
      fetch(1, 32'(4 * k), 0);
      exp_at(cyc + 1, "fetch_after_stall", w4[k], 1, 0, 0, 0);
      tick();
    end
    fetch(1, 32'h2, 0);
    exp_at(cyc + 1, "misaligned", NOP, 0, 1, 0, 0);
    tick();
    fetch(1, 32'(4 * DEPTH), 0);
    exp_at(cyc + 1, "out_of_range", NOP, 0, 1, 0, 0);
    tick();
    fetch(1, 32'h0, 6'b000010);
    exp_at(cyc + 1, "stall_hold_fault", NOP, 0, 1, 0, 0);
    tick();
    fetch(1, 32'hFFFF_FFF0, 0);
    exp_at(cyc + 1, "upper_bits", NOP, 0, 1, 0, 0);
    tick();
    fetch(0, 32'h4, 0);
    exp_at(cyc + 1, "ce_low", NOP, 0, 0, 0, 0);
    tick();
    fetch(1, 32'h4, 0);
    exp_at(cyc + 1, "fetch4", w4[1], 1, 0, 0, 0);
    tick();
    fetch(1, 32'h8, 6'b000010);
    bus.load_start_i = 1;
    exp_at(cyc + 1, "start_overrides_stall", NOP, 0, 0, 1, 0);
    tick();
    fetch(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_start_i = 0;
      if (i == 5) begin
        beat(0, 32'hBAD0_0000, 0);
        exp_at(cyc + 1, "gap_beat", NOP, 0, 0, 1, 0);
        tick();
      end
      beat(1, 32'hA000_0000 + 32'(i), 0);
      if (i == 8) bus.load_start_i = 1;
      if (i == DEPTH - 1) exp_at(cyc + 1, "depth_done", NOP, 0, 0, 0, 1);
      else                exp_at(cyc + 1, "depth_beat", NOP, 0, 0, 1, 0);
      tick();
    end
    bus.load_start_i = 0;
    beat(0, 0, 0);
    exp_at(cyc + 1, "depth_done_clears", NOP, 0, 0, 0, 0);
    tick();
    fetch(1, 32'(4 * (DEPTH - 1)), 0);
    exp_at(cyc + 1, "fetch_last_word", 32'hA000_000F, 1, 0, 0, 0);
    tick();
    fetch(1, 32'h0, 0);
    exp_at(cyc + 1, "fetch_word0", 32'hA000_0000, 1, 0, 0, 0);
    tick();
    fetch(1, 32'h20, 0);
    exp_at(cyc + 1, "start_ignored_in_load", 32'hA000_0008, 1, 0, 0, 0);
    tick();
    fetch(0, 0, 0);
    bus.load_start_i = 1;
    exp_at(cyc + 1, "partial_start", NOP, 0, 0, 1, 0);
    tick();
    bus.load_start_i = 0;
    beat(1, 32'hC000_0000, 0);
    exp_at(cyc + 1, "partial_beat", NOP, 0, 0, 1, 0);
    tick();
    beat(1, 32'hC000_0001, 0);
    tick();
    beat(0, 0, 0);
    #1 rst_n_i = 0;
    exp_at(cyc, "async_reset", NOP, 0, 0, 0, 0);
    exp_at(cyc + 1, "reset_held", NOP, 0, 0, 0, 0);
    tick();
    rst_n_i = 1;
    fetch(1, 32'h0, 0);
    exp_at(cyc + 1, "idle_after_reset", NOP, 0, 0, 0, 0);
    tick();
    fetch(0, 0, 0);
    bus.load_start_i = 1;
    exp_at(cyc + 1, "reload_start", NOP, 0, 0, 1, 0);
    tick();
    bus.load_start_i = 0;
    beat(1, 32'hDEAD_BEEF, 1);
    exp_at(cyc + 1, "reload_done", NOP, 0, 0, 0, 1);
    tick();
    beat(0, 0, 0);
    exp_at(cyc + 1, "reload_clears", NOP, 0, 0, 0, 0);
    tick();
    fetch(1, 32'h0, 0);
    exp_at(cyc + 1, "fetch_deadbeef", 32'hDEAD_BEEF, 1, 0, 0, 0);
    tick();
    fetch(1, 32'h4, 0);
    exp_at(cyc + 1, "retained_partial", 32'hC000_0001, 1, 0, 0, 0);
    tick();
    fetch(1, 32'h8, 0);
    exp_at(cyc + 1, "retained_old", 32'hA000_0002, 1, 0, 0, 0);
    tick();
    fetch(0, 0, 0);
    tick();
    tick();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
